// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default memory geometry and the start-request bounds check.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int DEF_MEM_BYTES = 100;
    localparam int DEF_MAX_WORDS = 25;

    // End address is formed in 33 bits so a huge base cannot wrap past the check.
    function automatic logic req_fault(
        input logic [31:0] base,
        input logic [7:0]  count,
        input logic [32:0] mem_bytes,
        input logic [31:0] max_words
    );
        logic [32:0] w_end;
        w_end = {1'b0, base} + {23'b0, count, 2'b00};
        return (base[1:0] != 2'b00) ||
               ({24'b0, count} > max_words) ||
               (w_end > mem_bytes);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams big-endian instruction bytes into instruction memory, holding the
// CPU while the load runs and reporting an XOR checksum of the loaded words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum,
    output logic [1:0]  dbg_state
);

    // Handshake: a byte moves when in_valid and in_ready are both high at a
    // rising edge; in_ready depends on state only, never on in_valid.

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_base;
    logic [9:0]  r_byte_idx;
    logic [9:0]  r_last_idx;
    logic [31:0] r_word;
    logic [31:0] r_checksum;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [7:0]  r_wr_data;

    logic        w_xfer;
    logic        w_last;
    logic        w_fault;
    logic        w_accept;
    logic [31:0] w_word_next;

    assign w_xfer      = in_valid & in_ready;
    assign w_last      = (r_byte_idx == r_last_idx);
    assign w_fault     = req_fault(base_addr, word_count, 33'(MEM_BYTES), 32'(MAX_WORDS));
    assign w_accept    = (r_state == ST_IDLE) && start && !w_fault;
    assign w_word_next = {r_word[23:0], in_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_fault)
                        w_state_next = ST_FAULT;
                    else if (word_count == 8'd0)
                        w_state_next = ST_FINISH;
                    else
                        w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && w_last)
                    w_state_next = ST_FINISH;
            end
            ST_FINISH: w_state_next = ST_IDLE;
            ST_FAULT:  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // The final byte's write lands in FINISH, so r_wr_en only extends hold
    // if a write ever trails the busy states.
    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        done      = (r_state == ST_FINISH);
        err       = (r_state == ST_FAULT);
        cpu_hold  = (r_state == ST_LOAD) || (r_state == ST_FINISH) || r_wr_en;
        wr_en     = r_wr_en;
        wr_addr   = r_wr_addr;
        wr_data   = r_wr_data;
        checksum  = r_checksum;
        dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_byte_idx <= '0;
            r_last_idx <= '0;
            r_word     <= '0;
            r_checksum <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_addr  <= r_base + {22'b0, r_byte_idx};
                r_wr_data  <= in_data;
                r_word     <= w_word_next;
                r_byte_idx <= r_byte_idx + 10'd1;
                if (r_byte_idx[1:0] == 2'b11)
                    r_checksum <= r_checksum ^ w_word_next;
            end
            if (w_accept) begin
                r_base     <= base_addr;
                r_last_idx <= {word_count, 2'b00} - 10'd1;
                r_byte_idx <= '0;
                r_word     <= '0;
                r_checksum <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream loads, stalls, rejected
// requests, empty loads, reset abort and ignored mid-load starts.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [31:0] checksum;
    logic [1:0]  dbg_state;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n_hold_bad = 0;
    logic        busy = 1'b0;
    logic [39:0] obs_q[$];
    int          obs_cyc[$];
    logic [39:0] exp_q[$];
    logic [7:0]  stim_q[$];

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, half a cycle after outputs settle.
    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            obs_cyc.push_back(cyc);
        end
        if (done) n_done++;
        if (err) n_err++;
        if (busy && !cpu_hold) n_hold_bad++;
        if (done) busy = 1'b0;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        n_done = 0;
        n_err = 0;
        n_hold_bad = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [7:0] c);
        start = 1'b1;
        base_addr = b;
        word_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bytes(input int gap, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 40'(in_ready), 40'(1));
            in_valid = 1'b1;
            in_data = stim_q[i];
            tick();
            in_valid = 1'b0;
            tick(gap);
        end
    endtask

    task automatic verify_writes(input logic [31:0] b, input int n, input int spacing);
        for (int i = 0; i < n; i++) exp_q.push_back({b + 32'(i), stim_q[i]});
        check("wr_count", 40'(obs_q.size()), 40'(n));
        for (int i = 0; i < n && obs_q.size() > 0; i++) begin
            check($sformatf("wr%0d", i), obs_q.pop_front(), exp_q.pop_front());
        end
        if (spacing > 0) begin
            for (int i = 1; i < obs_cyc.size(); i++)
                check($sformatf("wr_gap%0d", i), 40'(obs_cyc[i] - obs_cyc[i-1]), 40'(spacing));
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_state"},    40'(dbg_state), 40'(0));
        check({pfx, "_in_ready"}, 40'(in_ready),  40'(0));
        check({pfx, "_wr_en"},    40'(wr_en),     40'(0));
        check({pfx, "_cpu_hold"}, 40'(cpu_hold),  40'(0));
        check({pfx, "_done"},     40'(done),      40'(0));
        check({pfx, "_err"},      40'(err),       40'(0));
        check({pfx, "_wr_addr"},  40'(wr_addr),   40'(0));
        check({pfx, "_wr_data"},  40'(wr_data),   40'(0));
        check({pfx, "_checksum"}, 40'(checksum),  40'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        in_valid = 1'b0;
        in_data = '0;
        tick(3);
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // Two-word load, back-to-back bytes
        clear_obs();
        stim_q = '{8'h34, 8'h08, 8'h00, 8'h0B, 8'h34, 8'h09, 8'h00, 8'h08};
        do_start(32'd0, 8'd2);
        busy = 1'b1;
        send_bytes(0, 0, 7);
        tick(4);
        verify_writes(32'd0, 8, 1);
        check("b2b_checksum", 40'(checksum), 40'h0000010003);
        check("b2b_done_cnt", 40'(n_done), 40'(1));
        check("b2b_hold", 40'(n_hold_bad), 40'(0));
        check("b2b_hold_idle", 40'(cpu_hold), 40'(0));

        // Same load with in_valid toggling
        clear_obs();
        do_start(32'd0, 8'd2);
        busy = 1'b1;
        send_bytes(1, 0, 7);
        tick(4);
        verify_writes(32'd0, 8, 2);
        check("tog_checksum", 40'(checksum), 40'h0000010003);
        check("tog_done_cnt", 40'(n_done), 40'(1));
        check("tog_hold", 40'(n_hold_bad), 40'(0));

        // Rejected requests
        clear_obs();
        do_start(32'd2, 8'd1);
        check("misalign_err", 40'(err), 40'(1));
        check("misalign_ready", 40'(in_ready), 40'(0));
        tick();
        check("misalign_err_pulse", 40'(err), 40'(0));
        tick(2);
        check("misalign_no_wr", 40'(obs_q.size()), 40'(0));
        do_start(32'd96, 8'd2);
        check("overrun_err", 40'(err), 40'(1));
        tick(2);
        do_start(32'd0, 8'd26);
        check("count_err", 40'(err), 40'(1));
        tick(3);
        check("fault_no_wr", 40'(obs_q.size()), 40'(0));
        check("fault_err_cnt", 40'(n_err), 40'(3));
        check("fault_no_done", 40'(n_done), 40'(0));

        // Empty load
        clear_obs();
        do_start(32'd0, 8'd0);
        check("empty_done", 40'(done), 40'(1));
        check("empty_checksum", 40'(checksum), 40'(0));
        tick(3);
        check("empty_no_wr", 40'(obs_q.size()), 40'(0));
        check("empty_done_cnt", 40'(n_done), 40'(1));

        // Load ending exactly at the last memory byte
        clear_obs();
        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_start(32'd96, 8'd1);
        busy = 1'b1;
        send_bytes(0, 0, 3);
        tick(4);
        verify_writes(32'd96, 4, 1);
        check("top_checksum", 40'(checksum), 40'h00AABBCCDD);
        check("top_done_cnt", 40'(n_done), 40'(1));

        // Reset after the third byte of a two-word load
        clear_obs();
        stim_q = '{8'h34, 8'h08, 8'h00, 8'h0B, 8'h34, 8'h09, 8'h00, 8'h08};
        do_start(32'd0, 8'd2);
        send_bytes(0, 0, 2);
        in_valid = 1'b1;
        in_data = stim_q[3];
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        check_all_zero("abort");
        rst_n = 1'b1;
        tick(3);
        verify_writes(32'd0, 3, 1);
        check("abort_no_done", 40'(n_done), 40'(0));
        clear_obs();
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start(32'd8, 8'd1);
        busy = 1'b1;
        send_bytes(0, 0, 3);
        tick(4);
        verify_writes(32'd8, 4, 1);
        check("post_rst_checksum", 40'(checksum), 40'h0011223344);
        check("post_rst_done_cnt", 40'(n_done), 40'(1));

        // A start pulse mid-load is ignored
        clear_obs();
        stim_q = '{8'h34, 8'h08, 8'h00, 8'h0B, 8'h34, 8'h09, 8'h00, 8'h08};
        do_start(32'd0, 8'd2);
        busy = 1'b1;
        send_bytes(0, 0, 1);
        do_start(32'd40, 8'd1);
        send_bytes(0, 2, 7);
        tick(4);
        verify_writes(32'd0, 8, 0);
        check("midstart_checksum", 40'(checksum), 40'h0000010003);
        check("midstart_done_cnt", 40'(n_done), 40'(1));
        check("midstart_err_cnt", 40'(n_err), 40'(0));
        check("midstart_hold", 40'(n_hold_bad), 40'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
